// File: rtl/mycpu_v2.sv
// mycpu_v2: width-parametrised accumulator CPU core with a separate program
// counter, a 16-entry register file and a two-flag STATUS register.
// Build option: define MYCPU_V2_WAIT_EN to add the READY input and memory
// wait states; without it every memory access completes in one cycle.
module mycpu_v2 #(
  parameter int DW = 8,
  parameter int AW = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [DW-1:0] DI,
`ifdef MYCPU_V2_WAIT_EN
  input  logic          READY,
`endif
  output logic [AW-1:0] AB,
  output logic [DW-1:0] DO,
  output logic          RW,
  output logic          SYNC,
  output logic          HALTED
);

  typedef enum logic [2:0] {
    ST_FETCH1,
    ST_FETCH2,
    ST_MEMREAD,
    ST_MEMWRITE,
    ST_HALT
  } state_t;

  localparam logic [3:0] OP_SET  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_JPZ  = 4'h6;
  localparam logic [3:0] OP_CHG  = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_JPC  = 4'h9;
  localparam logic [3:0] OP_INCP = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hB;

  state_t         state;
  logic [AW-1:0]  pc;
  logic [7:0]     ir;
  logic           flag_z;
  logic           flag_c;
  logic [DW-1:0]  regs [16];

  logic           ready_ok;
  logic [3:0]     op;
  logic [3:0]     rsel;
  logic [DW-1:0]  acc;
  logic [DW-1:0]  rval;
  logic [2*DW-1:0] ptr_wide;
  logic [2*DW-1:0] ptr_wide_inc;
  logic [AW-1:0]  pointer;
  logic [AW-1:0]  jump;
  logic [AW-1:0]  pc_inc;
  logic [AW-1:0]  pc_next;
  logic [DW:0]    add_res;
  logic [DW:0]    sub_res;
  logic [DW-1:0]  and_res;

`ifdef MYCPU_V2_WAIT_EN
  assign ready_ok = READY;
`else
  assign ready_ok = 1'b1;
`endif

  // Decode straight from the instruction byte on DI while in FETCH2
  assign op   = DI[3:0];
  assign rsel = DI[7:4];
  assign acc  = regs[2];
  assign rval = regs[rsel];

  // POINTER and JUMP are register pairs truncated to the address width
  assign ptr_wide     = {regs[7], regs[6]};
  assign ptr_wide_inc = ptr_wide + 1'b1;
  assign pointer      = AW'(ptr_wide);
  assign jump         = AW'({regs[13], regs[12]});

  // The extra top bit of the subtraction is the borrow (A < R[r] unsigned)
  assign add_res = {1'b0, acc} + {1'b0, rval};
  assign sub_res = {1'b0, acc} - {1'b0, rval};
  assign and_res = acc & rval;

  assign pc_inc  = pc + AW'(1);
  assign pc_next = ((op == OP_JPZ && flag_z) || (op == OP_JPC && flag_c)) ? jump : pc_inc;

  // Instruction sequencer, datapath and registered bus outputs in one FSM
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_FETCH1;
      pc     <= RESET_PC;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      AB     <= RESET_PC;
      DO     <= '0;
      RW     <= 1'b0;
      SYNC   <= 1'b1;
      HALTED <= 1'b0;
    end else begin
      case (state)
        ST_FETCH1: begin
          SYNC  <= 1'b0;
          state <= ST_FETCH2;
        end

        ST_FETCH2: begin
          if (ready_ok) begin
            ir <= DI[7:0];
            case (op)
              OP_SET: begin
                pc    <= pc_inc;
                AB    <= pc_inc;
                state <= ST_MEMREAD;
              end
              OP_LDA: begin
                pc    <= pc_inc;
                AB    <= pointer;
                state <= ST_MEMREAD;
              end
              OP_STA: begin
                pc    <= pc_inc;
                AB    <= pointer;
                DO    <= rval;
                RW    <= 1'b1;
                state <= ST_MEMWRITE;
              end
              OP_HLT: begin
                HALTED <= 1'b1;
                state  <= ST_HALT;
              end
              default: begin
                case (op)
                  OP_AND: begin
                    regs[2] <= and_res;
                    flag_z  <= (and_res == '0);
                  end
                  OP_ADD: begin
                    regs[2] <= add_res[DW-1:0];
                    flag_c  <= add_res[DW];
                    flag_z  <= (add_res[DW-1:0] == '0);
                  end
                  OP_NOT: regs[rsel] <= ~rval;
                  OP_CHG: begin
                    regs[2]    <= rval;
                    regs[rsel] <= acc;
                  end
                  OP_SUB: begin
                    regs[2] <= sub_res[DW-1:0];
                    flag_c  <= sub_res[DW];
                    flag_z  <= (sub_res[DW-1:0] == '0);
                  end
                  OP_INCP: begin
                    regs[7] <= ptr_wide_inc[2*DW-1:DW];
                    regs[6] <= ptr_wide_inc[DW-1:0];
                  end
                  default: ;
                endcase
                pc    <= pc_next;
                AB    <= pc_next;
                SYNC  <= 1'b1;
                state <= ST_FETCH1;
              end
            endcase
          end
        end

        ST_MEMREAD: begin
          if (ready_ok) begin
            regs[ir[7:4]] <= DI;
            if (ir[3:0] == OP_SET) begin
              pc <= pc_inc;
              AB <= pc_inc;
            end else begin
              AB <= pc;
            end
            SYNC  <= 1'b1;
            state <= ST_FETCH1;
          end
        end

        ST_MEMWRITE: begin
          if (ready_ok) begin
            RW    <= 1'b0;
            AB    <= pc;
            SYNC  <= 1'b1;
            state <= ST_FETCH1;
          end
        end

        ST_HALT: ;

        default: state <= ST_FETCH1;
      endcase
    end
  end

endmodule

// File: tb/tb_mycpu_v2.sv
// tb_mycpu_v2: self-checking bench for mycpu_v2 (DW=8, AW=16, RESET_PC=0x0100).
// Expected fetch addresses and bus writes are queued when a program is loaded
// and popped by a negedge monitor as the core produces them.
module tb_mycpu_v2;

  localparam logic [15:0] RST_PC = 16'h0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  di;
  logic [15:0] ab;
  logic [7:0]  dout;
  logic        rw;
  logic        sync;
  logic        halted;

  logic [7:0]  mem [0:65535];
  logic [7:0]  prog [$];
  logic [15:0] fetchQ [$];
  logic [23:0] writeQ [$];
  logic [15:0] monFetch;
  logic [23:0] monWrite;
  int          extraFetch = 0;
  int          extraWrite = 0;
  bit          monOn = 1'b0;
  int          assertCount = 0;
  int          failCount = 0;

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Combinational memory read of whatever address the core drives
  assign di = mem[ab];

  mycpu_v2 #(.DW(8), .AW(16), .RESET_PC(RST_PC)) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .DI(di),
`ifdef MYCPU_V2_WAIT_EN
    .READY(ready),
`endif
    .AB(ab),
    .DO(dout),
    .RW(rw),
    .SYNC(sync),
    .HALTED(halted)
  );

  // Memory commits a write at the clock edge that ends an accepted write cycle
  always @(posedge clk) begin
    if (rst_n && rw && ready) mem[ab] <= dout;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard monitor: every fetch and every accepted write is matched in order
  always @(negedge clk) begin
    if (monOn && rst_n) begin
      if (sync) begin
        if (fetchQ.size() > 0) begin
          monFetch = fetchQ.pop_front();
          checkOutput("fetch_addr", ab, monFetch);
        end else begin
          extraFetch++;
        end
      end
      if (rw && ready) begin
        if (writeQ.size() > 0) begin
          monWrite = writeQ.pop_front();
          checkOutput("write_addr", ab, monWrite[23:8]);
          checkOutput("write_data", dout, monWrite[7:0]);
        end else begin
          extraWrite++;
        end
      end
    end
  end

  task automatic fillMem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h0B;
  endtask

  task automatic loadProg(input logic [15:0] addr);
    for (int i = 0; i < prog.size(); i++) mem[16'(addr + i)] = prog[i];
  endtask

  // Pulse reset (optionally checking reset outputs) and start the program
  task automatic applyStimulus(input bit checkRst);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (checkRst) begin
      checkOutput("rst_ab", ab, RST_PC);
      checkOutput("rst_do", dout, 8'h00);
      checkOutput("rst_rw", rw, 1'b0);
      checkOutput("rst_sync", sync, 1'b1);
      checkOutput("rst_halted", halted, 1'b0);
    end
    @(posedge clk);
    #2;
    extraFetch = 0;
    extraWrite = 0;
    monOn = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic waitHalt(input logic [15:0] haltAddr);
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("halt_reached", halted, 1'b1);
    checkOutput("halt_ab", ab, haltAddr);
  endtask

  task automatic endTest(input string name);
    checkOutput({name, "_fetch_left"}, fetchQ.size(), 0);
    checkOutput({name, "_write_left"}, writeQ.size(), 0);
    checkOutput({name, "_extra_fetch"}, extraFetch, 0);
    checkOutput({name, "_extra_write"}, extraWrite, 0);
    monOn = 1'b0;
    fetchQ.delete();
    writeQ.delete();
  endtask

  // SET/SET/ADD with carry, flag checks through JPZ/JPC, HLT freezes AB
  task automatic testAdd();
    int cycles = 0;
    fillMem();
    prog = '{8'h20, 8'hF0, 8'h30, 8'h20, 8'h34, 8'h60, 8'h00, 8'h70, 8'h02, 8'h22,
             8'hC0, 8'h80, 8'hD0, 8'h01, 8'h06, 8'h09};
    loadProg(16'h0100);
    mem[16'h0180] = 8'h0B;
    fetchQ = '{16'h0100, 16'h0102, 16'h0104, 16'h0105, 16'h0107, 16'h0109,
               16'h010A, 16'h010C, 16'h010E, 16'h010F, 16'h0180};
    writeQ = '{24'h020010};
    applyStimulus(1'b1);
    checkOutput("first_sync", sync, 1'b1);
    checkOutput("first_ab", ab, RST_PC);
    while (cycles < 50) begin
      @(negedge clk);
      if (sync && ab == 16'h0105) break;
      cycles++;
    end
    checkOutput("set_set_add_cycles", cycles, 8);
    waitHalt(16'h0180);
    repeat (3) @(negedge clk);
    checkOutput("halt_ab_frozen", ab, 16'h0180);
    checkOutput("halt_sync_low", sync, 1'b0);
    checkOutput("halt_still", halted, 1'b1);
    endTest("add");
  endtask

  // SUB with borrow then JPC; SUB to zero then JPZ taken, JPC not taken
  task automatic testSub();
    fillMem();
    prog = '{8'h20, 8'h05, 8'h30, 8'h06, 8'h38, 8'hC0, 8'h40, 8'hD0, 8'h00, 8'h09};
    loadProg(16'h0100);
    prog = '{8'h60, 8'h00, 8'h70, 8'h02, 8'h22, 8'h30, 8'hFF, 8'h38, 8'hC0, 8'h60, 8'h06};
    loadProg(16'h0040);
    prog = '{8'h09, 8'h22, 8'h0B};
    loadProg(16'h0060);
    fetchQ = '{16'h0100, 16'h0102, 16'h0104, 16'h0105, 16'h0107, 16'h0109,
               16'h0040, 16'h0042, 16'h0044, 16'h0045, 16'h0047, 16'h0048,
               16'h004A, 16'h0060, 16'h0061, 16'h0062};
    writeQ = '{24'h0200FF, 24'h020000};
    applyStimulus(1'b0);
    waitHalt(16'h0062);
    endTest("sub");
  endtask

  // STA to 0x00FF, INCP carry into R7, LDA from 0x0100, then CHG/AND/NOT/NOP
  task automatic testPointer();
    fillMem();
    prog = '{8'h55, 8'h60, 8'hFF, 8'h70, 8'h00, 8'h40, 8'hAA, 8'h42, 8'h0A, 8'h51,
             8'h52, 8'h57, 8'h30, 8'h0F, 8'h33, 8'h55, 8'h52, 8'h22, 8'h0C, 8'h0B};
    loadProg(16'h0100);
    fetchQ = '{16'h0100, 16'h0101, 16'h0103, 16'h0105, 16'h0107, 16'h0108,
               16'h0109, 16'h010A, 16'h010B, 16'h010C, 16'h010E, 16'h010F,
               16'h0110, 16'h0111, 16'h0112, 16'h0113};
    writeQ = '{24'h00FFAA, 24'h010055, 24'h0100FF, 24'h010005};
    applyStimulus(1'b0);
    waitHalt(16'h0113);
    endTest("ptr");
  endtask

  // LDA latency, with three READY-low cycles in MEMREAD when waits exist
  task automatic testWait();
    int n = 0;
    int cycles = 0;
    fillMem();
    prog = '{8'h60, 8'h00, 8'h70, 8'h03, 8'h41, 8'h42, 8'h0B};
    loadProg(16'h0100);
    mem[16'h0300] = 8'h77;
    fetchQ = '{16'h0100, 16'h0102, 16'h0104, 16'h0105, 16'h0106};
    writeQ = '{24'h030077};
    applyStimulus(1'b0);
    while (!(sync && ab == 16'h0104) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lda_fetch_seen", ab, 16'h0104);
    @(negedge clk);
    @(negedge clk);
    cycles = 2;
`ifdef MYCPU_V2_WAIT_EN
    ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      cycles++;
      checkOutput("wait_ab_held", ab, 16'h0300);
      checkOutput("wait_rw_held", rw, 1'b0);
      checkOutput("wait_do_held", dout, 8'h00);
      checkOutput("wait_no_sync", sync, 1'b0);
    end
    ready = 1'b1;
`endif
    while (!(sync && ab == 16'h0105) && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
`ifdef MYCPU_V2_WAIT_EN
    checkOutput("lda_cycles", cycles, 6);
`else
    checkOutput("lda_cycles", cycles, 3);
`endif
    waitHalt(16'h0106);
    endTest("wait");
  endtask

  // Reset asserted mid-MEMWRITE drops RW at once and restarts from RESET_PC
  task automatic testReset();
    int n = 0;
    fillMem();
    prog = '{8'h60, 8'h00, 8'h70, 8'h02, 8'h22, 8'h20, 8'h33, 8'h22, 8'h0B};
    loadProg(16'h0100);
    fetchQ = '{16'h0100, 16'h0102, 16'h0104, 16'h0105, 16'h0107,
               16'h0100, 16'h0102, 16'h0104, 16'h0105, 16'h0107, 16'h0108};
    writeQ = '{24'h020000, 24'h020033, 24'h020000, 24'h020033};
    applyStimulus(1'b0);
    while (!(rw && dout == 8'h33) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("memwrite_seen", rw, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rw", rw, 1'b0);
    checkOutput("async_ab", ab, RST_PC);
    checkOutput("async_sync", sync, 1'b1);
    checkOutput("async_do", dout, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    waitHalt(16'h0108);
    endTest("reset");
  endtask

  initial begin
    testAdd();
    testSub();
    testPointer();
    testWait();
    testReset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
